// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared types and helpers for the multiport register file: the
//          bulk-clear sequencer state encoding and the byte-merge helper used
//          by both the write path and the read bypass.
// Rev    : 1.0  initial release
// ============================================================================
package regfile_pkg;

  // Bulk-clear sequencer states
  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_BUSY = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_e;

  localparam int unsigned BYTE_W = 8;

  // Byte lane of a word after a byte-enabled write: the new byte when its
  // enable is set, otherwise the stored byte. Word merges apply this per lane.
  function automatic logic [BYTE_W-1:0] merge_byte(
    input logic [BYTE_W-1:0] old_byte,
    input logic [BYTE_W-1:0] new_byte,
    input logic              byte_en
  );
    return byte_en ? new_byte : old_byte;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clear_seq.sv
`default_nettype none
// ============================================================================
// Module : regfile_clear_seq
// Brief  : Bulk-clear sequencer. Walks every word index once (one per cycle)
//          and requests a reset-value write for it, then pulses clr_done.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_wr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  // Counter is one bit wider than the address so it can never wrap back
  // onto a live index.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  clr_state_e      state_q;
  logic [ADDR_W:0] cnt_q;
  logic            busy_q;
  logic            done_q;

  // Clear FSM with registered busy/done flags; busy spans exactly DEPTH cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          if (clr_req) begin
            state_q <= CLR_BUSY;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLR_BUSY: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == LAST_IDX) begin
            state_q <= CLR_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        CLR_DONE: begin
          // Requests arriving here are dropped, not queued.
          state_q <= CLR_IDLE;
          cnt_q   <= '0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= CLR_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy  = busy_q;
  assign clr_done  = done_q;
  assign clr_wr_en = busy_q;
  assign clr_addr  = cnt_q[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: rtl/multiport_regfile.sv
`default_nettype none
// ============================================================================
// Module : multiport_regfile
// Brief  : DEPTH x WIDTH register file with one byte-enabled write port, two
//          read ports, optional hardwired-zero word 0, write-to-read bypass,
//          optional registered reads and a sequenced bulk clear.
// Rev    : 1.0  initial release
// ============================================================================
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      DEPTH       = 32,
  parameter int unsigned      ADDR_W      = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               ZERO_REG    = 1'b1,
  parameter bit               BYPASS      = 1'b1,
  parameter bit               READ_REG    = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  output logic [WIDTH-1:0]     rd_data_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [WIDTH-1:0]     rd_data_b,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done
);

  localparam int unsigned NBYTES   = WIDTH / 8;
  localparam bit          FULL_MAP = (DEPTH == (1 << ADDR_W));

  logic [WIDTH-1:0]  w_mem [DEPTH];
  logic              w_clr_wr_en;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_in_range;
  logic              w_wr_accept;
  logic [1:0]        w_rd_in_range;
  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [WIDTH-1:0]  w_rd_out  [2];

  regfile_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .clr_wr_en (w_clr_wr_en),
    .clr_addr  (w_clr_addr)
  );

  // Address range checks only exist when DEPTH is not a power of two.
  generate
    if (FULL_MAP) begin : g_full_map
      assign w_wr_in_range = 1'b1;
      assign w_rd_in_range = 2'b11;
    end else begin : g_partial_map
      localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
      assign w_wr_in_range    = ({1'b0, wr_addr}   < DEPTH_EXT);
      assign w_rd_in_range[0] = ({1'b0, rd_addr_a} < DEPTH_EXT);
      assign w_rd_in_range[1] = ({1'b0, rd_addr_b} < DEPTH_EXT);
    end
  endgenerate

  // A write is dropped while clearing, when out of range, or when it
  // targets the hardwired-zero word.
  assign w_wr_accept = wr_en && !clr_busy && w_wr_in_range &&
                       !(ZERO_REG && (wr_addr == '0));

  // Storage: one word per generate slice so each has its own next-state.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      localparam logic [WIDTH-1:0] WORD_INIT = (ZERO_REG && (i == 0)) ? '0 : RESET_VALUE;

      logic [WIDTH-1:0] word_q;
      logic [WIDTH-1:0] word_d;
      logic             w_wr_hit;
      logic             w_clr_hit;

      assign w_wr_hit  = w_wr_accept && (wr_addr == ADDR_W'(i));
      assign w_clr_hit = w_clr_wr_en && (w_clr_addr == ADDR_W'(i));

      // Next word value: clear reload, byte-merged write, or hold.
      always_comb begin
        word_d = word_q;
        if (w_clr_hit) begin
          word_d = WORD_INIT;
        end else if (w_wr_hit) begin
          for (int b = 0; b < NBYTES; b++) begin
            word_d[8*b +: 8] = merge_byte(word_q[8*b +: 8], wr_data[8*b +: 8], wr_be[b]);
          end
        end
      end

      // Word register with asynchronous reset to its initial value.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          word_q <= WORD_INIT;
        end else begin
          word_q <= word_d;
        end
      end

      assign w_mem[i] = word_q;
    end
  endgenerate

  assign w_rd_addr[0] = rd_addr_a;
  assign w_rd_addr[1] = rd_addr_b;

  // Read ports: masked lookup, optional bypass merge, optional output register.
  generate
    for (genvar p = 0; p < 2; p++) begin : g_rd_port
      logic [WIDTH-1:0] w_stored;
      logic [WIDTH-1:0] w_merged;
      logic             w_byp_hit;

      assign w_stored  = (w_rd_in_range[p] && !(ZERO_REG && (w_rd_addr[p] == '0)))
                         ? w_mem[w_rd_addr[p]] : '0;
      assign w_byp_hit = BYPASS && w_wr_accept && (w_rd_addr[p] == wr_addr);

      // Overlay the in-flight write's enabled bytes on the stored word.
      always_comb begin
        w_merged = w_stored;
        if (w_byp_hit) begin
          for (int b = 0; b < NBYTES; b++) begin
            w_merged[8*b +: 8] = merge_byte(w_stored[8*b +: 8], wr_data[8*b +: 8], wr_be[b]);
          end
        end
      end

      if (READ_REG) begin : g_rd_reg
        logic [WIDTH-1:0] rd_q;
        // Capture the read result at the edge; visible the following cycle.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            rd_q <= '0;
          end else begin
            rd_q <= w_merged;
          end
        end
        assign w_rd_out[p] = rd_q;
      end else begin : g_rd_comb
        assign w_rd_out[p] = w_merged;
      end
    end
  endgenerate

  assign rd_data_a = w_rd_out[0];
  assign rd_data_b = w_rd_out[1];

endmodule
`default_nettype wire
